// File: rtl/ibus_dbus_arbiter_pkg.sv
// Shared definitions for the ibus/dbus arbiter. The bus bridge and the core also use
// them when they decode the arbiter state or the request size.
package ibus_dbus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_I,
    ADDR_D,
    DATA_I,
    DATA_D
  } arb_state_t;

  localparam logic [2:0] MSIZE_WORD = 3'b010;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive priority-side grants taken while the other side waits.
// The at_max output tells the arbiter to hand the next tie to the non-priority side.
module arb_starve_counter #(
  parameter int MAX_CONSEC = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       at_max
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

  assign at_max = (cnt == MAX_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 4'd0;
    end else if (inc) begin
      cnt <= at_max ? cnt : cnt + 4'd1;
    end else if (clr) begin
      cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// Shares one downstream memory bus between the fetch and data ports. Only one transaction
// is outstanding at a time, and the owner keeps the bus from its grant until data_ok.
module ibus_dbus_arbiter
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter bit PRIO_DATA  = 1'b1,
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_data,
  output logic        m_valid,
  output logic        m_is_write,
  output logic [31:0] m_addr,
  output logic [2:0]  m_size,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_data
);

  arb_state_t state, state_next;
  logic [3:0] starve_cnt;
  logic       at_max;
  logic       d_wins_tie, grant_d_idle, sel_d, req_phase;
  logic       prio_sel, other_valid, inc, clr;

  // On a tie the priority side wins until it has starved the other side MAX_CONSEC times.
  assign d_wins_tie   = PRIO_DATA ? !at_max : at_max;
  assign grant_d_idle = d_valid & (!i_valid | d_wins_tie);
  assign req_phase    = (state == IDLE && (i_valid || d_valid)) ||
                        state == ADDR_I || state == ADDR_D;
  assign sel_d        = (state == ADDR_D) || (state == IDLE && grant_d_idle);

  assign m_addr     = sel_d ? d_addr : i_addr;
  assign m_size     = sel_d ? d_size : MSIZE_WORD;
  assign m_strobe   = sel_d ? d_strobe : 4'd0;
  assign m_wdata    = sel_d ? d_wdata : 32'd0;
  assign m_is_write = sel_d & (|d_strobe);
  assign i_data     = m_data;
  assign d_data     = m_data;

  assign prio_sel    = PRIO_DATA ? sel_d : !sel_d;
  assign other_valid = PRIO_DATA ? i_valid : d_valid;
  assign inc         = m_valid & m_addr_ok & prio_sel & other_valid;
  assign clr         = m_valid & m_addr_ok & !inc;

  arb_starve_counter #(.MAX_CONSEC(MAX_CONSEC)) u_starve (
    .clk    (clk),
    .resetn (resetn),
    .inc    (inc),
    .clr    (clr),
    .cnt    (starve_cnt),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ADDR_I, ADDR_D: begin
        if (req_phase) begin
          if (m_addr_ok) state_next = m_data_ok ? IDLE : (sel_d ? DATA_D : DATA_I);
          else           state_next = sel_d ? ADDR_D : ADDR_I;
        end
      end
      DATA_I, DATA_D: if (m_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshakes are gated by resetn so nothing leaks out while reset is held.
  always_comb begin
    m_valid   = 1'b0;
    i_addr_ok = 1'b0;
    d_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    if (resetn) begin
      case (state)
        IDLE, ADDR_I, ADDR_D: begin
          m_valid = req_phase;
          if (req_phase && m_addr_ok) begin
            i_addr_ok = !sel_d;
            d_addr_ok = sel_d;
            i_data_ok = !sel_d & m_data_ok;
            d_data_ok = sel_d & m_data_ok;
          end
        end
        DATA_I:  i_data_ok = m_data_ok;
        DATA_D:  d_data_ok = m_data_ok;
        default: ;
      endcase
    end
  end

endmodule
